// File: rtl/sccb_slave_regfile_if.sv
// SCCB pin bundle between an SCCB master and sccb_slave_regfile.
// Signal names are from the slave's point of view:
//   i_sioc     SCCB clock from the master
//   i_siod_in  resolved SIOD level seen on the pin
//   o_siod_out level the slave drives (1 when not driving)
//   o_siod_oe  1 = slave drives SIOD
interface sccb_slave_regfile_if;
  logic i_sioc;
  logic i_siod_in;
  logic o_siod_out;
  logic o_siod_oe;

  modport slave (
    input  i_sioc,
    input  i_siod_in,
    output o_siod_out,
    output o_siod_oe
  );

  modport master (
    output i_sioc,
    output i_siod_in,
    input  o_siod_out,
    input  o_siod_oe
  );
endinterface

// File: rtl/sccb_slave_regfile.sv
// SCCB slave with an internal register file (camera control-path emulation).
// Programmable ID, 1/2-byte big-endian sub-address, auto-incrementing pointer,
// register read-back, open-drain output enable and a write-notify strobe.
//
// Optional feature macro: SCCB_SLAVE_ACK_EN
//   defined   -> slave pulls SIOD low during the 9th bit of every byte it receives
//   undefined -> 9th bit is don't-care, slave only drives read data bits
//
// Ports:
//   i_clk, i_rst    system clock (>= 20x SIOC), async active-high reset
//   sccb            SIOC/SIOD pin bundle (slave modport)
//   o_busy          1 whenever the FSM is not IDLE
//   o_wr_strobe     one-cycle pulse per register written
//   o_wr_addr       pointer value of the register just written
//   o_wr_data       byte just written
//   o_txn_err       one-cycle pulse on an aborted/malformed transaction
module sccb_slave_regfile #(
  parameter logic [7:0]  SLAVE_ID       = 8'h78,
  parameter int unsigned SUB_ADDR_BYTES = 2,
  parameter int unsigned REG_DEPTH      = 256,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  sccb_slave_regfile_if.slave           sccb,
  output logic                          o_busy,
  output logic                          o_wr_strobe,
  output logic [8*SUB_ADDR_BYTES-1:0]   o_wr_addr,
  output logic [7:0]                    o_wr_data,
  output logic                          o_txn_err
);

  localparam int unsigned PTR_W = 8 * SUB_ADDR_BYTES;
  localparam int unsigned IDX_W = $clog2(REG_DEPTH);
  localparam logic [3:0]  BCNT_LAST = 4'd7;
  localparam logic [3:0]  BCNT_ACK  = 4'd8;
  localparam logic [1:0]  SUB_LAST  = 2'(SUB_ADDR_BYTES - 1);
`ifdef SCCB_SLAVE_ACK_EN
  localparam logic ACK_EN = 1'b1;
`else
  localparam logic ACK_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_ID, S_ID_ACK, S_SUB, S_WR, S_RD, S_RD_END, S_IGNORE
  } state_t;

  state_t r_state, w_state_nxt;

  logic [SYNC_STAGES-1:0] r_sioc_sync, r_siod_sync;
  logic                   r_sc_d, r_sd_d;
  logic                   w_sc, w_sd;
  logic                   w_start, w_stop, w_rise, w_fall;

  logic [3:0]       r_bcnt;
  logic [7:0]       r_shift;
  logic [1:0]       r_sub_idx;
  logic [PTR_W-1:0] r_sub_acc;
  logic [PTR_W-1:0] r_ptr;
  logic [7:0]       r_regs [REG_DEPTH];

  logic [7:0]       w_byte;
  logic [PTR_W-1:0] w_sub_acc_nxt;
  logic [IDX_W-1:0] w_idx;
  logic             w_rd_bit;
  logic             w_id_match;
  logic             w_in_byte;
  logic             w_ack_cell;

  logic             w_oe_nxt, w_sdo_nxt, w_err_nxt, w_wr_fire;
  logic             r_oe, r_sdo, r_busy, r_wr_strobe, r_txn_err;
  logic [PTR_W-1:0] r_wr_addr;
  logic [7:0]       r_wr_data;

  // Input synchronisers plus one delayed copy for edge detection
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sioc_sync <= '1;
      r_siod_sync <= '1;
      r_sc_d      <= 1'b1;
      r_sd_d      <= 1'b1;
    end else begin
      r_sioc_sync <= {r_sioc_sync[SYNC_STAGES-2:0], sccb.i_sioc};
      r_siod_sync <= {r_siod_sync[SYNC_STAGES-2:0], sccb.i_siod_in};
      r_sc_d      <= w_sc;
      r_sd_d      <= w_sd;
    end
  end

  assign w_sc    = r_sioc_sync[SYNC_STAGES-1];
  assign w_sd    = r_siod_sync[SYNC_STAGES-1];
  assign w_start = w_sc & r_sd_d & ~w_sd;
  assign w_stop  = w_sc & ~r_sd_d & w_sd;
  // START/STOP outrank a coincident clock edge
  assign w_rise  = w_sc & ~r_sc_d & ~w_start & ~w_stop;
  assign w_fall  = ~w_sc & r_sc_d;

  assign w_byte        = {r_shift[6:0], w_sd};
  assign w_sub_acc_nxt = PTR_W'({r_sub_acc, w_byte});
  assign w_idx         = r_ptr[IDX_W-1:0];
  assign w_rd_bit      = r_regs[w_idx][3'(BCNT_LAST - r_bcnt)];
  assign w_id_match    = (r_shift[7:1] == SLAVE_ID[7:1]);
  assign w_in_byte     = (r_state == S_ID) || (r_state == S_SUB) ||
                         (r_state == S_WR) || (r_state == S_RD);
  assign w_ack_cell    = ((r_state == S_ID_ACK) && w_id_match) ||
                         (((r_state == S_SUB) || (r_state == S_WR)) && (r_bcnt == BCNT_ACK));

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    if (w_stop) begin
      w_state_nxt = S_IDLE;
    end else if (w_start) begin
      w_state_nxt = S_ID;
    end else if (w_rise) begin
      case (r_state)
        S_ID:     if (r_bcnt == BCNT_LAST) w_state_nxt = S_ID_ACK;
        S_ID_ACK: begin
          if (!w_id_match)     w_state_nxt = S_IGNORE;
          else if (r_shift[0]) w_state_nxt = S_RD;
          else                 w_state_nxt = S_SUB;
        end
        S_SUB:    if ((r_bcnt == BCNT_ACK) && (r_sub_idx == SUB_LAST)) w_state_nxt = S_WR;
        S_RD:     if ((r_bcnt == BCNT_ACK) && w_sd) w_state_nxt = S_RD_END;
        default:  ;
      endcase
    end
  end

  // Output logic: SIOD drive, write notify and error pulse
  always_comb begin
    w_oe_nxt  = r_oe;
    w_sdo_nxt = r_sdo;
    w_err_nxt = 1'b0;
    w_wr_fire = 1'b0;
    if (w_start || w_stop) begin
      w_oe_nxt  = 1'b0;
      w_sdo_nxt = 1'b1;
      // The SIOC rise that opens a STOP/repeated START lands as one bit, so a
      // single pending bit is still a byte boundary.
      w_err_nxt = w_in_byte && (r_bcnt >= 4'd2) && (r_bcnt <= BCNT_LAST);
    end else begin
      w_wr_fire = w_rise && (r_state == S_WR) && (r_bcnt == BCNT_LAST);
      if (w_fall) begin
        w_oe_nxt  = 1'b0;
        w_sdo_nxt = 1'b1;
        if ((r_state == S_RD) && (r_bcnt <= BCNT_LAST)) begin
          w_oe_nxt  = 1'b1;
          w_sdo_nxt = w_rd_bit;
        end else if (ACK_EN && w_ack_cell) begin
          w_oe_nxt  = 1'b1;
          w_sdo_nxt = 1'b0;
        end
      end
    end
  end

  // Bit counter, shifter, pointer and register file
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_bcnt    <= '0;
      r_shift   <= '0;
      r_sub_idx <= '0;
      r_sub_acc <= '0;
      r_ptr     <= '0;
      for (int i = 0; i < int'(REG_DEPTH); i++) r_regs[i] <= '0;
    end else if (w_start || w_stop) begin
      r_bcnt    <= '0;
      r_sub_idx <= '0;
    end else if (w_rise) begin
      case (r_state)
        S_ID, S_SUB, S_WR: begin
          if (r_bcnt == BCNT_ACK) begin
            r_bcnt <= '0;
            if (r_state == S_SUB) r_sub_idx <= r_sub_idx + 2'd1;
          end else begin
            r_shift <= w_byte;
            r_bcnt  <= r_bcnt + 4'd1;
            if (r_bcnt == BCNT_LAST) begin
              if (r_state == S_SUB) begin
                // Pointer only changes once the whole sub-address is in
                r_sub_acc <= w_sub_acc_nxt;
                if (r_sub_idx == SUB_LAST) r_ptr <= w_sub_acc_nxt;
              end else if (r_state == S_WR) begin
                r_regs[w_idx] <= w_byte;
                r_ptr         <= r_ptr + PTR_W'(1);
              end
            end
          end
        end
        S_ID_ACK: r_bcnt <= '0;
        S_RD: begin
          if (r_bcnt == BCNT_ACK) begin
            r_bcnt <= '0;
          end else begin
            r_bcnt <= r_bcnt + 4'd1;
            if (r_bcnt == BCNT_LAST) r_ptr <= r_ptr + PTR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Registered outputs
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_oe        <= 1'b0;
      r_sdo       <= 1'b1;
      r_busy      <= 1'b0;
      r_wr_strobe <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_txn_err   <= 1'b0;
    end else begin
      r_oe        <= w_oe_nxt;
      r_sdo       <= w_sdo_nxt;
      r_busy      <= (w_state_nxt != S_IDLE);
      r_wr_strobe <= w_wr_fire;
      r_txn_err   <= w_err_nxt;
      if (w_wr_fire) begin
        r_wr_addr <= r_ptr;
        r_wr_data <= w_byte;
      end
    end
  end

  assign sccb.o_siod_out = r_sdo;
  assign sccb.o_siod_oe  = r_oe;
  assign o_busy          = r_busy;
  assign o_wr_strobe     = r_wr_strobe;
  assign o_wr_addr       = r_wr_addr;
  assign o_wr_data       = r_wr_data;
  assign o_txn_err       = r_txn_err;

endmodule

// File: doc/sccb_slave_regfile.md
Name: sccb_slave_regfile

Overview:
Parametrised SCCB slave with an internal register file. It is the next-generation bench and camera-emulation model for the OV5642 control path.
Adds programmable ID, 1- or 2-byte sub-address, auto-incrementing register pointer, true register read-back, open-drain output enable, stop/repeated-start handling and a write-notify strobe.
Sits opposite the SCCB master on the SIOC/SIOD pins, in simulation and in loopback FPGA builds.

Parameters:
SLAVE_ID, 8'h78, 7-bit write ID in bits [7:1]; bit 0 is ignored. The read ID is SLAVE_ID|1.
SUB_ADDR_BYTES, 2, sub-address length in bytes; legal values 1 or 2.
REG_DEPTH, 256, register count; power of 2, at most 2^(8*SUB_ADDR_BYTES).
SYNC_STAGES, 2, input synchroniser depth for SIOC and SIOD; minimum 2.

Ports:
i_clk  in  1  system clock, at least 20x the SIOC rate
i_rst  in  1  reset, asynchronous, active-high
i_sioc  in  1  SCCB clock from master
i_siod_in  in  1  SCCB data from the pin
o_siod_out  out  1  data driven by the slave; 1 when not driving
o_siod_oe  out  1  1 = slave drives SIOD
o_busy  out  1  1 whenever state is not IDLE
o_wr_strobe  out  1  one-cycle pulse per register written
o_wr_addr  out  8*SUB_ADDR_BYTES  pointer value of the register just written
o_wr_data  out  8  byte just written
o_txn_err  out  1  one-cycle pulse on an aborted or malformed transaction

Behaviour:
- One clock; reset is asynchronous and active-high (i_rst), clock i_clk.
- Reset values: o_siod_out=1, o_siod_oe=0, o_busy=0, o_wr_strobe=0, o_wr_addr=0, o_wr_data=0, o_txn_err=0. State=IDLE, pointer=0, all registers=8'h00. Synchroniser flops reset to 1.
- Events are derived from the synchronised signals (sc, sd) and their previous values:
  - START: sd falls while sc=1.
  - STOP: sd rises while sc=1.
  - RISE / FALL: edges of sc.
- Bits are sampled on RISE, MSB first. Slave drive changes take effect on the cycle after FALL.
- States:
  - IDLE: START -> ID.
  - ID: shift 8 bits, then -> ID_ACK.
  - ID_ACK: 9th bit. If ID[7:1] matches SLAVE_ID[7:1]: with ID[0]=0 -> SUB; with ID[0]=1 -> RD. On mismatch -> IGNORE.
  - SUB: SUB_ADDR_BYTES bytes, each followed by a 9th bit; the bytes load the pointer big-endian. Then -> WR.
  - WR: each 8-bit byte writes reg[pointer mod REG_DEPTH].
    - On the cycle after the 8th RISE: o_wr_strobe=1, o_wr_addr=pointer, o_wr_data=byte.
    - The pointer then increments, wrapping at 2^(8*SUB_ADDR_BYTES).
    - The 9th bit follows; then the next byte.
  - RD: drives reg[pointer mod REG_DEPTH] MSB first.
    - oe=1 from the FALL following the ID 9th bit until the FALL after the 8th bit.
    - The pointer increments after the byte.
    - The 9th bit (master NA/ACK) is sampled. 0 -> next byte; 1 -> RD_END.
  - RD_END: wait for STOP.
  - IGNORE: oe=0; wait for STOP.
- STOP in any state -> IDLE on the next cycle; oe=0.
- STOP or START before a byte completes: the partial byte is discarded (no write, pointer unchanged) and o_txn_err pulses. SUB partial bytes leave the pointer unchanged.
- START in any non-IDLE state (repeated start) -> ID with the bit count cleared; no o_txn_err if it lands on a byte boundary.
- A write-only transaction (address phase then STOP) sets the pointer for a following read transaction, as per SCCB 2-phase read.
- The pointer persists across transactions; only reset clears it.
- RISE coincident with STOP/START: the START/STOP takes priority and the bit is not counted.
- Reset mid-operation: immediate return to reset values; SIOD is released within the same cycle.

Optional Feature:
SCCB_SLAVE_ACK_EN.
- Defined: the slave drives SIOD=0 (oe=1) for the 9th bit of every byte it receives (ID match, sub-address, write data), from the preceding FALL to the following FALL.
- Undefined: the 9th bit is SCCB don't-care and the slave never drives it; oe stays 0 except in RD data bits.

Test Plan:
Write 0x78, 0x30, 0x08, 0x82, STOP -> one o_wr_strobe with o_wr_addr=16'h3008 and o_wr_data=8'h82; pointer=0x3009.
Write 0x78, 0x30, 0x08, STOP; then read 0x79, bits, NA=1, STOP -> slave drives 1,0,0,0,0,0,1,0 (0x82) with oe high for exactly 8 bit cells; pointer=0x3009.
Burst write at 0x00FE of 0x11, 0x22, 0x33 (REG_DEPTH=256) -> strobes at 0x00FE, 0x00FF, 0x0100; the reg[0] read-back gives 0x33.
ID 0x42 followed by 3 bytes -> no strobe, oe never 1, o_busy drops the cycle after STOP.
STOP after 4 bits of a data byte -> o_txn_err pulses once, no strobe, register unchanged.
Assert i_rst during RD bit 3 -> oe=0 and o_siod_out=1 immediately, state IDLE; the next full write transaction succeeds.
